caseg_scan_ctrl: RTL

//  Parametrised time-multiplexed 7-segment scan driver (common-anode board, DIGITS positions).

---
 rtl/caseg_scan_ctrl_if.sv | 26 ++
 rtl/caseg_scan_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/caseg_scan_ctrl_if.sv
// Display bus between the data-formatting logic and the 7-segment scan driver.
// The formatting side (master) presents the next display image and a load strobe;
// the scan driver (slave) returns the board pin values and the frame pulse.
interface caseg_scan_ctrl_if #(
    parameter int DIGITS   = 8,
    parameter int BRIGHT_W = 4
);
    logic [4*DIGITS-1:0] digits_in;
    logic [DIGITS-1:0]   dp_in;
    logic [DIGITS-1:0]   blank_in;
    logic [BRIGHT_W-1:0] bright_in;
    logic                load;
    logic [DIGITS-1:0]   sel;
    logic [7:0]          seg;
    logic                frame_done;

    modport master (
        output digits_in, dp_in, blank_in, bright_in, load,
        input  sel, seg, frame_done
    );

    modport slave (
        input  digits_in, dp_in, blank_in, bright_in, load,
        output sel, seg, frame_done
    );
endinterface

// File: rtl/caseg_scan_ctrl.sv
// Time-multiplexed 7-segment scan driver for a common-anode board.
// A shadow image is captured on load and copied to the active image only at the
// frame boundary, so a frame is never shown half old and half new. Each digit slot
// opens with a dark gap against ghosting, followed by a PWM-gated ON window.
module caseg_scan_ctrl #(
    parameter int DIGITS      = 8,
    parameter int SCAN_CNT    = 50000,
    parameter int GHOST_CYC   = 500,
    parameter int BRIGHT_W    = 4,
    parameter int HEX_MODE    = 0,
    parameter int SEG_ACT_LOW = 1,
    parameter int SEL_ACT_LOW = 1
) (
    input  logic              sclk,
    input  logic              nrst,
    caseg_scan_ctrl_if.slave  bus
);

    localparam int SLOT_W = (SCAN_CNT > 1) ? $clog2(SCAN_CNT) : 1;
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [SLOT_W-1:0]   SLOT_LAST   = SLOT_W'(SCAN_CNT - 1);
    localparam logic [SLOT_W-1:0]   GHOST_END   = SLOT_W'(GHOST_CYC);
    localparam logic [IDX_W-1:0]    IDX_LAST    = IDX_W'(DIGITS - 1);
    localparam logic [BRIGHT_W-1:0] BRIGHT_FULL = {BRIGHT_W{1'b1}};
    localparam logic [DIGITS-1:0]   SEL_OFF     = (SEL_ACT_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
    localparam logic [7:0]          SEG_OFF     = (SEG_ACT_LOW != 0) ? 8'hFF : 8'h00;

    // Active-high gfedcba glyph for a 4-bit digit code; codes above 9 depend on HEX_MODE.
    function automatic logic [6:0] decode_glyph(input logic [3:0] code);
        logic [6:0] glyph;
        case (code)
            4'h0:    glyph = 7'h3F;
            4'h1:    glyph = 7'h06;
            4'h2:    glyph = 7'h5B;
            4'h3:    glyph = 7'h4F;
            4'h4:    glyph = 7'h66;
            4'h5:    glyph = 7'h6D;
            4'h6:    glyph = 7'h7D;
            4'h7:    glyph = 7'h07;
            4'h8:    glyph = 7'h7F;
            4'h9:    glyph = 7'h6F;
            4'hA:    glyph = (HEX_MODE != 0) ? 7'h77 : 7'h00;
            4'hB:    glyph = (HEX_MODE != 0) ? 7'h7C : 7'h40;
            4'hC:    glyph = (HEX_MODE != 0) ? 7'h39 : 7'h00;
            4'hD:    glyph = (HEX_MODE != 0) ? 7'h5E : 7'h00;
            4'hE:    glyph = (HEX_MODE != 0) ? 7'h79 : 7'h00;
            4'hF:    glyph = (HEX_MODE != 0) ? 7'h71 : 7'h00;
            default: glyph = 7'h00;
        endcase
        return glyph;
    endfunction

    // Scan position and PWM phase
    logic [SLOT_W-1:0]   slot_cnt_r;
    logic [IDX_W-1:0]    idx_r;
    logic [BRIGHT_W-1:0] pwm_cnt_r;

    // Shadow image (written by load) and active image (currently displayed)
    logic [4*DIGITS-1:0] sh_digits_r;
    logic [DIGITS-1:0]   sh_dp_r;
    logic [DIGITS-1:0]   sh_blank_r;
    logic [BRIGHT_W-1:0] sh_bright_r;
    logic [4*DIGITS-1:0] act_digits_r;
    logic [DIGITS-1:0]   act_dp_r;
    logic [DIGITS-1:0]   act_blank_r;
    logic [BRIGHT_W-1:0] act_bright_r;

    // Registered pins
    logic [DIGITS-1:0]   sel_r;
    logic [7:0]          seg_r;
    logic                frame_done_r;

    // Next-state and decode signals
    logic                slot_wrap_s;
    logic                frame_end_s;
    logic                ghost_done_s;
    logic                pwm_on_s;
    logic                lit_s;
    logic [SLOT_W-1:0]   slot_nxt_s;
    logic [IDX_W-1:0]    idx_nxt_s;
    logic [BRIGHT_W-1:0] pwm_nxt_s;
    logic [3:0]          cur_digit_s;
    logic [DIGITS-1:0]   onehot_s;
    logic [7:0]          seg_raw_s;
    logic [DIGITS-1:0]   sel_nxt_s;
    logic [7:0]          seg_nxt_s;

    // Counter advance, lit decision and pin values for the next cycle
    always_comb begin
        slot_nxt_s   = slot_cnt_r;
        idx_nxt_s    = idx_r;
        pwm_nxt_s    = {BRIGHT_W{1'b0}};
        sel_nxt_s    = SEL_OFF;
        seg_nxt_s    = SEG_OFF;

        slot_wrap_s  = (slot_cnt_r == SLOT_LAST);
        frame_end_s  = slot_wrap_s && (idx_r == IDX_LAST);
        ghost_done_s = (slot_cnt_r >= GHOST_END);

        if (slot_wrap_s) begin
            slot_nxt_s = {SLOT_W{1'b0}};
            if (idx_r == IDX_LAST) begin
                idx_nxt_s = {IDX_W{1'b0}};
            end else begin
                idx_nxt_s = idx_r + IDX_W'(1);
            end
        end else begin
            slot_nxt_s = slot_cnt_r + SLOT_W'(1);
            idx_nxt_s  = idx_r;
        end

        // pwm_cnt tracks (slot_cnt - GHOST_CYC) mod 2^BRIGHT_W; it is zero
        // whenever the next cycle is still inside the dark gap.
        if (ghost_done_s && !slot_wrap_s) begin
            pwm_nxt_s = pwm_cnt_r + BRIGHT_W'(1);
        end else begin
            pwm_nxt_s = {BRIGHT_W{1'b0}};
        end

        pwm_on_s    = (act_bright_r == BRIGHT_FULL) || (pwm_cnt_r < act_bright_r);
        lit_s       = ghost_done_s && !act_blank_r[idx_r] && pwm_on_s;
        cur_digit_s = act_digits_r[{idx_r, 2'b00} +: 4];
        onehot_s    = DIGITS'(1'b1) << idx_r;
        seg_raw_s   = {act_dp_r[idx_r], decode_glyph(cur_digit_s)};

        if (lit_s) begin
            sel_nxt_s = (SEL_ACT_LOW != 0) ? ~onehot_s : onehot_s;
            seg_nxt_s = (SEG_ACT_LOW != 0) ? ~seg_raw_s : seg_raw_s;
        end else begin
            sel_nxt_s = SEL_OFF;
            seg_nxt_s = SEG_OFF;
        end
    end

    // Scan counters, frame pulse and registered pin outputs
    always_ff @(posedge sclk) begin
        if (!nrst) begin
            slot_cnt_r   <= {SLOT_W{1'b0}};
            idx_r        <= {IDX_W{1'b0}};
            pwm_cnt_r    <= {BRIGHT_W{1'b0}};
            frame_done_r <= 1'b0;
            sel_r        <= SEL_OFF;
            seg_r        <= SEG_OFF;
        end else begin
            slot_cnt_r   <= slot_nxt_s;
            idx_r        <= idx_nxt_s;
            pwm_cnt_r    <= pwm_nxt_s;
            frame_done_r <= frame_end_s;
            sel_r        <= sel_nxt_s;
            seg_r        <= seg_nxt_s;
        end
    end

    // Shadow capture on load; shadow-to-active copy at the frame boundary.
    // Both use the pre-edge shadow, so a load on the boundary cycle waits a frame.
    always_ff @(posedge sclk) begin
        if (!nrst) begin
            sh_digits_r  <= {(4*DIGITS){1'b0}};
            sh_dp_r      <= {DIGITS{1'b0}};
            sh_blank_r   <= {DIGITS{1'b1}};
            sh_bright_r  <= {BRIGHT_W{1'b0}};
            act_digits_r <= {(4*DIGITS){1'b0}};
            act_dp_r     <= {DIGITS{1'b0}};
            act_blank_r  <= {DIGITS{1'b1}};
            act_bright_r <= {BRIGHT_W{1'b0}};
        end else begin
            if (bus.load) begin
                sh_digits_r <= bus.digits_in;
                sh_dp_r     <= bus.dp_in;
                sh_blank_r  <= bus.blank_in;
                sh_bright_r <= bus.bright_in;
            end else begin
                sh_digits_r <= sh_digits_r;
                sh_dp_r     <= sh_dp_r;
                sh_blank_r  <= sh_blank_r;
                sh_bright_r <= sh_bright_r;
            end
            if (frame_end_s) begin
                act_digits_r <= sh_digits_r;
                act_dp_r     <= sh_dp_r;
                act_blank_r  <= sh_blank_r;
                act_bright_r <= sh_bright_r;
            end else begin
                act_digits_r <= act_digits_r;
                act_dp_r     <= act_dp_r;
                act_blank_r  <= act_blank_r;
                act_bright_r <= act_bright_r;
            end
        end
    end

    assign bus.sel        = sel_r;
    assign bus.seg        = seg_r;
    assign bus.frame_done = frame_done_r;

endmodule
